// File: rtl/prbs_pd_checker.sv
// PRBS-15 pattern-detect checker: hunts a 32-bit sync word, then checks bytes.
// Ports: CLK/RST, in_valid/in byte stream, clear_cnt; detect/lock/error outs.
module prbs_pd_checker #(
  parameter logic [31:0] PATTERN     = 32'hABCDEFCD,
  parameter logic [14:0] SEED        = 15'h7FFF,
  parameter int          LOSS_THRESH = 4
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        in_valid,
  input  logic [7:0]  in,
  input  logic        clear_cnt,
  output logic        pattern_detected,
  output logic        locked,
  output logic        err_flag,
  output logic [15:0] err_count
);

  typedef enum logic {HUNT, CHECK} state_t;

  state_t      state, state_n;
  logic [23:0] win, win_n;
  logic [2:0]  fill, fill_n;
  logic [14:0] lfsr, lfsr_n, lfsr_adv;
  logic [7:0]  exp_byte;
  logic [3:0]  cerr, cerr_n;
  logic        det_n, eflag_n;
  logic [15:0] cnt_n;

  // Eight LFSR steps; first generated bit is the byte MSB.
  always_comb begin
    lfsr_adv = lfsr;
    exp_byte = '0;
    for (int i = 7; i >= 0; i--) begin
      exp_byte[i] = lfsr_adv[14] ^ lfsr_adv[13];
      lfsr_adv    = {lfsr_adv[13:0], exp_byte[i]};
    end
  end

  always_comb begin
    state_n = state;
    win_n   = win;
    fill_n  = fill;
    lfsr_n  = lfsr;
    cerr_n  = cerr;
    det_n   = 1'b0;
    eflag_n = 1'b0;
    cnt_n   = err_count;
    if (in_valid) begin
      unique case (state)
        HUNT: begin
          // Only the last three bytes need keeping;
          // the fourth is the incoming one.
          win_n = {win[15:0], in};
          if (fill != 3'd4) fill_n = fill + 3'd1;
          if (fill >= 3'd3 && {win, in} == PATTERN) begin
            state_n = CHECK;
            lfsr_n  = SEED;
            cerr_n  = '0;
            det_n   = 1'b1;
          end
        end
        CHECK: begin
          lfsr_n = lfsr_adv;
          if (in != exp_byte) begin
            eflag_n = 1'b1;
            cerr_n  = cerr + 4'd1;
            if (err_count != 16'hFFFF)
              cnt_n = err_count + 16'd1;
            if (cerr_n == 4'(LOSS_THRESH)) begin
              state_n = HUNT;
              win_n   = '0;
              fill_n  = '0;
            end
          end else begin
            cerr_n = '0;
          end
        end
      endcase
    end
    if (clear_cnt) cnt_n = '0;
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state            <= HUNT;
      win              <= '0;
      fill             <= '0;
      lfsr             <= SEED;
      cerr             <= '0;
      pattern_detected <= 1'b0;
      err_flag         <= 1'b0;
      err_count        <= '0;
    end else begin
      state            <= state_n;
      win              <= win_n;
      fill             <= fill_n;
      lfsr             <= lfsr_n;
      cerr             <= cerr_n;
      pattern_detected <= det_n;
      err_flag         <= eflag_n;
      err_count        <= cnt_n;
    end
  end

  assign locked = (state == CHECK);

endmodule

// File: tb/tb_prbs_pd_checker.sv
// Bench for prbs_pd_checker: vector table plus short hand-written sequences.
// Second instance uses an all-zero sync word.
module tb_prbs_pd_checker;

  logic        clk = 1'b0;
  logic        rst;
  logic        v, clr;
  logic [7:0]  din;
  logic        det, lck, ef;
  logic [15:0] cnt;
  logic        v0, clr0;
  logic [7:0]  din0;
  logic        det0, lck0, ef0;
  logic [15:0] cnt0;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  prbs_pd_checker dut (
    .CLK(clk), .RST(rst), .in_valid(v), .in(din),
    .clear_cnt(clr), .pattern_detected(det), .locked(lck),
    .err_flag(ef), .err_count(cnt)
  );

  prbs_pd_checker #(.PATTERN(32'h0)) dut0 (
    .CLK(clk), .RST(rst), .in_valid(v0), .in(din0),
    .clear_cnt(clr0), .pattern_detected(det0), .locked(lck0),
    .err_flag(ef0), .err_count(cnt0)
  );

  typedef struct {
    bit          v;
    logic [7:0]  d;
    bit          clr;
    bit          det;
    bit          lck;
    bit          ef;
    logic [15:0] cnt;
  } vec_t;

  vec_t tv[$];

  task automatic add(bit v_, logic [7:0] d_, bit c_,
                     bit dt, bit lk, bit e, logic [15:0] n);
    vec_t t;
    t.v = v_; t.d = d_; t.clr = c_;
    t.det = dt; t.lck = lk; t.ef = e; t.cnt = n;
    tv.push_back(t);
  endtask

  // Expected PRBS-15 byte idx after a lock with seed 7FFF.
  function automatic logic [7:0] prbs(int idx);
    logic [14:0] s;
    logic [7:0]  b;
    s = 15'h7FFF;
    b = '0;
    for (int k = 0; k <= idx; k++)
      for (int i = 7; i >= 0; i--) begin
        b[i] = s[14] ^ s[13];
        s    = {s[13:0], b[i]};
      end
    return b;
  endfunction

  task automatic chk(string name, logic [15:0] act, logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic drive(bit v_, logic [7:0] d_, bit c_);
    v = v_; din = d_; clr = c_;
    @(posedge clk);
    #1;
  endtask

  task automatic chk_all(string tag, bit dt, bit lk, bit e,
                         logic [15:0] n);
    chk({tag, "_det"}, 16'(det), 16'(dt));
    chk({tag, "_lock"}, 16'(lck), 16'(lk));
    chk({tag, "_eflag"}, 16'(ef), 16'(e));
    chk({tag, "_cnt"}, cnt, n);
  endtask

  initial begin
    rst = 1'b1; v = 1'b1; din = 8'hAB; clr = 1'b0;
    v0 = 1'b0; din0 = 8'h00; clr0 = 1'b0;

    // Reset held with a valid byte present.
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk_all("reset", 0, 0, 0, 16'h0);
    chk("reset0_lock", 16'(lck0), 16'h0);
    rst = 1'b0; v = 1'b0;

    // All-zero sync word: fill guard blocks early match.
    for (int i = 0; i < 4; i++) begin
      v0 = 1'b1; din0 = 8'h00;
      @(posedge clk); #1;
      chk($sformatf("zp%0d_det", i), 16'(det0), (i == 3) ? 16'h1 : 16'h0);
      chk($sformatf("zp%0d_lock", i), 16'(lck0), (i == 3) ? 16'h1 : 16'h0);
    end
    v0 = 1'b0;
    @(posedge clk); #1;
    chk("zp_det_pulse", 16'(det0), 16'h0);

    // Lock on sync word.
    add(1, 8'hAB, 0, 0, 0, 0, 0);
    add(1, 8'hCD, 0, 0, 0, 0, 0);
    add(1, 8'hEF, 0, 0, 0, 0, 0);
    add(1, 8'hCD, 0, 1, 1, 0, 0);
    // 32 clean bytes; first four hand-derived.
    add(1, 8'h00, 0, 0, 1, 0, 0);
    add(1, 8'h02, 0, 0, 1, 0, 0);
    add(1, 8'h00, 0, 0, 1, 0, 0);
    add(1, 8'h0C, 0, 0, 1, 0, 0);
    for (int i = 4; i < 32; i++)
      add(1, prbs(i), 0, 0, 1, 0, 0);
    // Single corrupted byte (fifth of this run).
    for (int i = 32; i < 41; i++) begin
      if (i == 36)
        add(1, prbs(i) ^ 8'h01, 0, 0, 1, 1, 1);
      else
        add(1, prbs(i), 0, 0, 1, 0, (i < 36) ? 16'd0 : 16'd1);
    end
    // Idle clear.
    add(0, 8'h55, 1, 0, 1, 0, 0);
    // Four consecutive bad bytes drop lock.
    for (int k = 0; k < 4; k++)
      add(1, prbs(41 + k) ^ 8'hFF, 0, 0, k < 3, 1, 16'(k + 1));
    // Relock.
    add(1, 8'h00, 0, 0, 0, 0, 4);
    add(1, 8'hAB, 0, 0, 0, 0, 4);
    add(1, 8'hCD, 0, 0, 0, 0, 4);
    add(1, 8'hEF, 0, 0, 0, 0, 4);
    add(1, 8'hCD, 0, 1, 1, 0, 4);
    // Bubbles: LFSR must hold while idle.
    add(0, 8'h00, 0, 0, 1, 0, 4);
    add(1, prbs(0), 0, 0, 1, 0, 4);
    add(0, 8'h33, 0, 0, 1, 0, 4);
    add(0, 8'h44, 0, 0, 1, 0, 4);
    add(1, prbs(1), 0, 0, 1, 0, 4);
    add(0, 8'h00, 0, 0, 1, 0, 4);
    add(1, prbs(2), 0, 0, 1, 0, 4);
    add(1, prbs(3), 0, 0, 1, 0, 4);
    add(1, prbs(4) ^ 8'h10, 0, 0, 1, 1, 5);
    add(0, 8'h00, 0, 0, 1, 0, 5);
    add(1, prbs(5), 0, 0, 1, 0, 5);
    // Clear wins over a simultaneous mismatch.
    add(1, prbs(6) ^ 8'h01, 1, 0, 1, 1, 0);
    add(1, prbs(7), 0, 0, 1, 0, 0);

    foreach (tv[i]) begin
      drive(tv[i].v, tv[i].d, tv[i].clr);
      chk_all($sformatf("v%0d", i), tv[i].det, tv[i].lck,
              tv[i].ef, tv[i].cnt);
    end

    // Mid-operation reset while locked.
    rst = 1'b1;
    drive(1, 8'hAB, 0);
    chk_all("midrst", 0, 0, 0, 16'h0);
    rst = 1'b0;
    drive(1, 8'hCD, 0); chk_all("rl0", 0, 0, 0, 16'h0);
    drive(1, 8'hAB, 0); chk_all("rl1", 0, 0, 0, 16'h0);
    drive(1, 8'hCD, 0); chk_all("rl2", 0, 0, 0, 16'h0);
    drive(1, 8'hEF, 0); chk_all("rl3", 0, 0, 0, 16'h0);
    drive(1, 8'hCD, 0); chk_all("rl4", 1, 1, 0, 16'h0);
    drive(1, 8'h00, 0); chk_all("rl5", 0, 1, 0, 16'h0);
    drive(0, 8'h00, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
